// File: rtl/cpu_ctrl_fsm.sv
// rtl/cpu_ctrl_fsm.sv - multicycle control FSM for the 16-bit CPU
//
// Sequences fetch, decode, R-type execute, load, store, conditional jump
// and jump-and-link. It waits on a memory ready handshake and flags illegal
// encodings.
//
// Ports:
//   i_clk, i_reset        clock, synchronous active-low reset
//   i_instr_in            instruction word from memory
//   i_mem_ready           memory completes current request this cycle
//   i_flags               {Z, C, F, N, L} from the flag register
//   o_opcode              latched instruction to ALU decode (EXEC_R only)
//   o_mux_a_sel/b_sel     regfile read port selects
//   o_reg_en              one-hot regfile write enable
//   o_alu_sel             writeback source: 1 = ALU, 0 = memory data
//   o_wb_pc_sel           writeback the PC (JAL link)
//   o_pc_sel              address mux: 1 = PC, 0 = port A register
//   o_mem_req, o_mem_we   memory request / write
//   o_flag_en             flag register load
//   o_pc_en, o_pc_ld      PC update enable / load jump target
//   o_illegal             one-cycle pulse on illegal instruction
//   o_state_dbg           current state encoding
module cpu_ctrl_fsm #(
  parameter int         NUM_REGS = 16,
  parameter logic [3:0] CMP_OPC  = 4'b1011
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [15:0]         i_instr_in,
  input  logic                i_mem_ready,
  input  logic [4:0]          i_flags,
  output logic [15:0]         o_opcode,
  output logic [3:0]          o_mux_a_sel,
  output logic [3:0]          o_mux_b_sel,
  output logic [NUM_REGS-1:0] o_reg_en,
  output logic                o_alu_sel,
  output logic                o_wb_pc_sel,
  output logic                o_pc_sel,
  output logic                o_mem_req,
  output logic                o_mem_we,
  output logic                o_flag_en,
  output logic                o_pc_en,
  output logic                o_pc_ld,
  output logic                o_illegal,
  output logic [3:0]          o_state_dbg
);

  typedef enum logic [3:0] {
    S_RESET   = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_EXEC_R  = 4'd3,
    S_MEM     = 4'd4,
    S_LOAD_WB = 4'd5,
    S_JUMP    = 4'd6,
    S_JAL     = 4'd7,
    S_ILLEGAL = 4'd8
  } state_t;

  localparam logic [4:0]          NREG = 5'(NUM_REGS);
  localparam logic [NUM_REGS-1:0] ONE  = NUM_REGS'(1);

  state_t        r_state;
  state_t        w_next;
  logic [15:0]   r_instr;

  logic [3:0]          w_op;
  logic [3:0]          w_ra;
  logic [3:0]          w_sub;
  logic [3:0]          w_rb;
  logic                w_ra_bad;
  logic                w_rb_bad;
  logic                w_is_store;
  logic                w_cond;
  logic                w_z, w_c, w_f, w_n, w_l;
  logic [NUM_REGS-1:0] w_dst_onehot;

  assign w_op         = r_instr[15:12];
  assign w_ra         = r_instr[11:8];
  assign w_sub        = r_instr[7:4];
  assign w_rb         = r_instr[3:0];
  assign w_ra_bad     = {1'b0, w_ra} >= NREG;
  assign w_rb_bad     = {1'b0, w_rb} >= NREG;
  assign w_is_store   = (w_sub == 4'b0100);
  // Only reached with w_ra < NUM_REGS, so the shift never falls off the end.
  assign w_dst_onehot = ONE << w_ra;
  assign {w_z, w_c, w_f, w_n, w_l} = i_flags;
  assign o_state_dbg  = r_state;

  always_comb begin
    w_cond = 1'b0;
    case (w_ra)
      4'b0000: w_cond = w_z;
      4'b0001: w_cond = !w_z;
      4'b0010: w_cond = w_c;
      4'b0011: w_cond = !w_c;
      4'b0100: w_cond = w_l;
      4'b0101: w_cond = !w_l;
      4'b0110: w_cond = w_n;
      4'b0111: w_cond = !w_n;
      4'b1000: w_cond = w_f;
      4'b1001: w_cond = !w_f;
      4'b1010: w_cond = !w_l && !w_z;
      4'b1011: w_cond = w_l || w_z;
      4'b1100: w_cond = !w_n && !w_z;
      4'b1101: w_cond = w_n || w_z;
      4'b1110: w_cond = 1'b1;
      default: w_cond = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= S_RESET;
      r_instr <= 16'h0000;
    end else begin
      r_state <= w_next;
      if (r_state == S_FETCH && i_mem_ready) begin
        r_instr <= i_instr_in;
      end
    end
  end

  always_comb begin
    w_next      = r_state;
    o_opcode    = 16'h0000;
    o_mux_a_sel = 4'h0;
    o_mux_b_sel = 4'h0;
    o_reg_en    = '0;
    o_alu_sel   = 1'b1;
    o_wb_pc_sel = 1'b0;
    o_pc_sel    = 1'b1;
    o_mem_req   = 1'b0;
    o_mem_we    = 1'b0;
    o_flag_en   = 1'b0;
    o_pc_en     = 1'b0;
    o_pc_ld     = 1'b0;
    o_illegal   = 1'b0;
    case (r_state)
      S_RESET: w_next = S_FETCH;
      S_FETCH: begin
        o_mem_req = 1'b1;
        if (i_mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        o_pc_en = 1'b1;
        if (w_op != 4'b0100) begin
          w_next = (w_ra_bad || w_rb_bad) ? S_ILLEGAL : S_EXEC_R;
        end else begin
          case (w_sub)
            4'b0000, 4'b0100: w_next = (w_ra_bad || w_rb_bad) ? S_ILLEGAL : S_MEM;
            // [11:8] is the condition code here, not a register.
            4'b1100:          w_next = w_rb_bad ? S_ILLEGAL : S_JUMP;
            4'b1000:          w_next = (w_ra_bad || w_rb_bad) ? S_ILLEGAL : S_JAL;
            default:          w_next = S_ILLEGAL;
          endcase
        end
      end
      S_EXEC_R: begin
        o_opcode    = r_instr;
        o_mux_a_sel = w_ra;
        o_mux_b_sel = w_rb;
        o_flag_en   = 1'b1;
        if (w_op != CMP_OPC) o_reg_en = w_dst_onehot;
        w_next = S_FETCH;
      end
      S_MEM: begin
        o_mem_req   = 1'b1;
        o_pc_sel    = 1'b0;
        o_mux_a_sel = w_rb;
        if (w_is_store) begin
          o_mem_we    = 1'b1;
          o_mux_b_sel = w_ra;
        end
        if (i_mem_ready) w_next = w_is_store ? S_FETCH : S_LOAD_WB;
      end
      S_LOAD_WB: begin
        o_alu_sel = 1'b0;
        o_reg_en  = w_dst_onehot;
        w_next    = S_FETCH;
      end
      S_JUMP: begin
        o_mux_a_sel = w_rb;
        o_pc_en     = w_cond;
        o_pc_ld     = w_cond;
        w_next      = S_FETCH;
      end
      S_JAL: begin
        // Target is read on port A in the same cycle as the link write, so a
        // link register equal to the target register yields the old value.
        o_wb_pc_sel = 1'b1;
        o_reg_en    = w_dst_onehot;
        o_mux_a_sel = w_rb;
        o_pc_en     = 1'b1;
        o_pc_ld     = 1'b1;
        w_next      = S_FETCH;
      end
      S_ILLEGAL: begin
        o_illegal = 1'b1;
        w_next    = S_FETCH;
      end
      default: w_next = S_RESET;
    endcase
  end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// tb/tb_cpu_ctrl_fsm.sv - self-checking bench for cpu_ctrl_fsm
module tb_cpu_ctrl_fsm;

  logic        clk;
  logic        rst;
  logic [15:0] instr;
  logic        rdy;
  logic [4:0]  flags;

  logic [15:0] opcode, opcode8;
  logic [3:0]  ma, mb, ma8, mb8;
  logic [15:0] reg_en;
  logic [7:0]  reg_en8;
  logic        alu_sel, wb_pc_sel, pc_sel, mem_req, mem_we, flag_en, pc_en, pc_ld, illegal;
  logic        alu_sel8, wb_pc_sel8, pc_sel8, mem_req8, mem_we8, flag_en8, pc_en8, pc_ld8, illegal8;
  logic [3:0]  st, st8;

  int checks = 0;
  int errors = 0;

  cpu_ctrl_fsm #(.NUM_REGS(16)) dut (
    .i_clk(clk), .i_reset(rst), .i_instr_in(instr), .i_mem_ready(rdy), .i_flags(flags),
    .o_opcode(opcode), .o_mux_a_sel(ma), .o_mux_b_sel(mb), .o_reg_en(reg_en),
    .o_alu_sel(alu_sel), .o_wb_pc_sel(wb_pc_sel), .o_pc_sel(pc_sel), .o_mem_req(mem_req),
    .o_mem_we(mem_we), .o_flag_en(flag_en), .o_pc_en(pc_en), .o_pc_ld(pc_ld),
    .o_illegal(illegal), .o_state_dbg(st)
  );

  cpu_ctrl_fsm #(.NUM_REGS(8)) dut8 (
    .i_clk(clk), .i_reset(rst), .i_instr_in(instr), .i_mem_ready(rdy), .i_flags(flags),
    .o_opcode(opcode8), .o_mux_a_sel(ma8), .o_mux_b_sel(mb8), .o_reg_en(reg_en8),
    .o_alu_sel(alu_sel8), .o_wb_pc_sel(wb_pc_sel8), .o_pc_sel(pc_sel8), .o_mem_req(mem_req8),
    .o_mem_we(mem_we8), .o_flag_en(flag_en8), .o_pc_en(pc_en8), .o_pc_ld(pc_ld8),
    .o_illegal(illegal8), .o_state_dbg(st8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ctl = {alu_sel, wb_pc_sel, pc_sel, mem_req, mem_we, flag_en, pc_en, pc_ld, illegal}
  localparam logic [8:0] DEF  = 9'b101000000;
  localparam logic [8:0] FET  = 9'b101100000;
  localparam logic [8:0] DEC  = 9'b101000100;
  localparam logic [8:0] EXR  = 9'b101001000;
  localparam logic [8:0] MEML = 9'b100100000;
  localparam logic [8:0] MEMS = 9'b100110000;
  localparam logic [8:0] LWB  = 9'b001000000;
  localparam logic [8:0] JT   = 9'b101000110;
  localparam logic [8:0] JALC = 9'b111000110;
  localparam logic [8:0] ILL  = 9'b101000001;

  typedef struct {
    logic        rst;
    logic [15:0] instr;
    logic        rdy;
    logic [4:0]  flags;
    logic [3:0]  st;
    logic [15:0] reg_en;
    logic [3:0]  ma;
    logic [3:0]  mb;
    logic [15:0] op;
    logic [8:0]  ctl;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic r, input logic [15:0] i, input logic rd, input logic [4:0] f,
                     input logic [3:0] s, input logic [15:0] re, input logic [3:0] a,
                     input logic [3:0] b, input logic [15:0] o, input logic [8:0] c);
    vec_t v;
    v.rst = r; v.instr = i; v.rdy = rd; v.flags = f; v.st = s;
    v.reg_en = re; v.ma = a; v.mb = b; v.op = o; v.ctl = c;
    tv.push_back(v);
  endtask

  task automatic check8(input string name, input logic [3:0] es, input logic [7:0] ere,
                        input logic eill);
    checks++;
    if (st8 !== es || reg_en8 !== ere || illegal8 !== eill) begin
      errors++;
      $display("FAIL %s: got state=%0d reg_en=%h illegal=%b, expected state=%0d reg_en=%h illegal=%b",
               name, st8, reg_en8, illegal8, es, ere, eill);
    end
  endtask

  initial begin
    logic [8:0] act_ctl;
    rst = 1'b0; instr = 16'h0000; rdy = 1'b1; flags = 5'b00000;
    repeat (3) @(posedge clk);

    // reset held, then release
    add(0, 16'h0000, 1, 5'h00, 0, 16'h0000, 0, 0, 16'h0000, DEF);
    add(1, 16'h0000, 1, 5'h00, 0, 16'h0000, 0, 0, 16'h0000, DEF);
    // R-type 0312
    add(1, 16'h0312, 1, 5'h00, 1, 16'h0000, 0, 0, 16'h0000, FET);
    add(1, 16'h0312, 1, 5'h00, 2, 16'h0000, 0, 0, 16'h0000, DEC);
    add(1, 16'h0312, 1, 5'h00, 3, 16'h0008, 3, 2, 16'h0312, EXR);
    // compare B312: flags only
    add(1, 16'hB312, 1, 5'h00, 1, 16'h0000, 0, 0, 16'h0000, FET);
    add(1, 16'hB312, 1, 5'h00, 2, 16'h0000, 0, 0, 16'h0000, DEC);
    add(1, 16'hB312, 1, 5'h00, 3, 16'h0000, 3, 2, 16'hB312, EXR);
    // load 4502 with 2 wait states
    add(1, 16'h4502, 1, 5'h00, 1, 16'h0000, 0, 0, 16'h0000, FET);
    add(1, 16'h4502, 1, 5'h00, 2, 16'h0000, 0, 0, 16'h0000, DEC);
    add(1, 16'h4502, 0, 5'h00, 4, 16'h0000, 2, 0, 16'h0000, MEML);
    add(1, 16'h4502, 0, 5'h00, 4, 16'h0000, 2, 0, 16'h0000, MEML);
    add(1, 16'h4502, 1, 5'h00, 4, 16'h0000, 2, 0, 16'h0000, MEML);
    add(1, 16'h4502, 1, 5'h00, 5, 16'h0020, 0, 0, 16'h0000, LWB);
    // store 4547
    add(1, 16'h4547, 1, 5'h00, 1, 16'h0000, 0, 0, 16'h0000, FET);
    add(1, 16'h4547, 1, 5'h00, 2, 16'h0000, 0, 0, 16'h0000, DEC);
    add(1, 16'h4547, 1, 5'h00, 4, 16'h0000, 7, 5, 16'h0000, MEMS);
    // jump on Z, taken
    add(1, 16'h40C3, 1, 5'h00, 1, 16'h0000, 0, 0, 16'h0000, FET);
    add(1, 16'h40C3, 1, 5'h00, 2, 16'h0000, 0, 0, 16'h0000, DEC);
    add(1, 16'h40C3, 1, 5'h10, 6, 16'h0000, 3, 0, 16'h0000, JT);
    // jump on Z, not taken
    add(1, 16'h40C3, 1, 5'h00, 1, 16'h0000, 0, 0, 16'h0000, FET);
    add(1, 16'h40C3, 1, 5'h00, 2, 16'h0000, 0, 0, 16'h0000, DEC);
    add(1, 16'h40C3, 1, 5'h00, 6, 16'h0000, 3, 0, 16'h0000, DEF);
    // L | Z with L=0, Z=1: taken
    add(1, 16'h4BC3, 1, 5'h00, 1, 16'h0000, 0, 0, 16'h0000, FET);
    add(1, 16'h4BC3, 1, 5'h00, 2, 16'h0000, 0, 0, 16'h0000, DEC);
    add(1, 16'h4BC3, 1, 5'h10, 6, 16'h0000, 3, 0, 16'h0000, JT);
    // never, with every flag set
    add(1, 16'h4FC3, 1, 5'h00, 1, 16'h0000, 0, 0, 16'h0000, FET);
    add(1, 16'h4FC3, 1, 5'h00, 2, 16'h0000, 0, 0, 16'h0000, DEC);
    add(1, 16'h4FC3, 1, 5'h1F, 6, 16'h0000, 3, 0, 16'h0000, DEF);
    // JAL 4E84
    add(1, 16'h4E84, 1, 5'h00, 1, 16'h0000, 0, 0, 16'h0000, FET);
    add(1, 16'h4E84, 1, 5'h00, 2, 16'h0000, 0, 0, 16'h0000, DEC);
    add(1, 16'h4E84, 1, 5'h00, 7, 16'h4000, 4, 0, 16'h0000, JALC);
    // illegal sub-opcode 4010
    add(1, 16'h4010, 1, 5'h00, 1, 16'h0000, 0, 0, 16'h0000, FET);
    add(1, 16'h4010, 1, 5'h00, 2, 16'h0000, 0, 0, 16'h0000, DEC);
    add(1, 16'h4010, 1, 5'h00, 8, 16'h0000, 0, 0, 16'h0000, ILL);
    // fetch wait state, then reset mid-MEM
    add(1, 16'h4502, 0, 5'h00, 1, 16'h0000, 0, 0, 16'h0000, FET);
    add(1, 16'h4502, 1, 5'h00, 1, 16'h0000, 0, 0, 16'h0000, FET);
    add(1, 16'h4502, 1, 5'h00, 2, 16'h0000, 0, 0, 16'h0000, DEC);
    add(1, 16'h4502, 0, 5'h00, 4, 16'h0000, 2, 0, 16'h0000, MEML);
    add(0, 16'h4502, 0, 5'h00, 4, 16'h0000, 2, 0, 16'h0000, MEML);
    add(0, 16'h4502, 1, 5'h00, 0, 16'h0000, 0, 0, 16'h0000, DEF);
    add(1, 16'h4502, 1, 5'h00, 0, 16'h0000, 0, 0, 16'h0000, DEF);
    add(1, 16'h4502, 0, 5'h00, 1, 16'h0000, 0, 0, 16'h0000, FET);
    add(1, 16'h4502, 0, 5'h00, 1, 16'h0000, 0, 0, 16'h0000, FET);

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      rst = tv[i].rst; instr = tv[i].instr; rdy = tv[i].rdy; flags = tv[i].flags;
      #1;
      checks++;
      if (st !== tv[i].st) begin
        errors++;
        $display("FAIL row%0d state: got %0d, expected %0d", i, st, tv[i].st);
      end
      act_ctl = {alu_sel, wb_pc_sel, pc_sel, mem_req, mem_we, flag_en, pc_en, pc_ld, illegal};
      checks++;
      if (reg_en !== tv[i].reg_en || ma !== tv[i].ma || mb !== tv[i].mb ||
          opcode !== tv[i].op || act_ctl !== tv[i].ctl) begin
        errors++;
        $display("FAIL row%0d outputs: got reg_en=%h a=%h b=%h op=%h ctl=%b, expected reg_en=%h a=%h b=%h op=%h ctl=%b",
                 i, reg_en, ma, mb, opcode, act_ctl,
                 tv[i].reg_en, tv[i].ma, tv[i].mb, tv[i].op, tv[i].ctl);
      end
    end

    // NUM_REGS = 8: register 9 is out of range, register 7 is the top legal one
    @(negedge clk); rst = 1'b0; rdy = 1'b1; instr = 16'h0912;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); #1; check8("n8_fetch", 4'd1, 8'h00, 1'b0);
    @(negedge clk); #1; check8("n8_decode", 4'd2, 8'h00, 1'b0);
    @(negedge clk); #1; check8("n8_illegal", 4'd8, 8'h00, 1'b1);
    instr = 16'h0712;
    @(negedge clk); #1; check8("n8_refetch", 4'd1, 8'h00, 1'b0);
    @(negedge clk); #1; check8("n8_decode2", 4'd2, 8'h00, 1'b0);
    @(negedge clk); #1; check8("n8_exec_r7", 4'd3, 8'h80, 1'b0);
    @(negedge clk); #1; check8("n8_back", 4'd1, 8'h00, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
